// File: rtl/allegro_codec_pkg.sv
// Shared types for the Allegro codec configuration path.
// APB transfer types plus the APB manager FSM state and response bundle.
package allegro_codec_pkg;

  typedef logic [19:0] dcd_targ_cfg_apb_addr_t;
  typedef logic [31:0] dcd_targ_cfg_apb_data_t;
  typedef logic [3:0]  dcd_targ_cfg_apb_strb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_mgr_state_e;

  typedef struct packed {
    dcd_targ_cfg_apb_data_t rdata;
    logic                   err;
    logic                   timeout;
  } apb_mgr_rsp_t;

endpackage

// File: rtl/allegro_codec_cfg_apb_manager.sv
// Single-outstanding APB manager for the codec configuration target.
// Converts a command handshake into one APB transfer with wait-state timeout.
module allegro_codec_cfg_apb_manager
  import allegro_codec_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [2:0]  Pprot         = 3'b000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_write,
  input  dcd_targ_cfg_apb_addr_t i_cmd_addr,
  input  dcd_targ_cfg_apb_data_t i_cmd_wdata,
  input  dcd_targ_cfg_apb_strb_t i_cmd_wstrb,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output dcd_targ_cfg_apb_data_t o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic                   o_rsp_timeout,
  output dcd_targ_cfg_apb_addr_t o_paddr,
  output dcd_targ_cfg_apb_data_t o_pwdata,
  output dcd_targ_cfg_apb_strb_t o_pstrb,
  output logic                   o_psel,
  output logic                   o_penable,
  output logic                   o_pwrite,
  output logic [2:0]             o_pprot,
  input  logic                   i_pready,
  input  logic                   i_pslverr,
  input  dcd_targ_cfg_apb_data_t i_prdata
);

  localparam int unsigned CntW =
    (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntLim =
    TimeoutEn ? CntW'(TimeoutCycles - 1) : '0;

  apb_mgr_state_e         state_q;
  logic                   cmd_ready_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  dcd_targ_cfg_apb_addr_t paddr_q;
  dcd_targ_cfg_apb_data_t pwdata_q;
  dcd_targ_cfg_apb_strb_t pstrb_q;
  logic                   rsp_valid_q;
  apb_mgr_rsp_t           rsp_q;
  logic [CntW-1:0]        wait_cnt_q;
  logic [CntW-1:0]        wait_cnt_d;
  logic                   timeout_hit;

  // A ready slave in the limit cycle wins over the timeout.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (wait_cnt_q != CntMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    timeout_hit = TimeoutEn && (wait_cnt_q == CntLim) && !i_pready;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      wait_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && i_cmd_valid) begin
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= i_cmd_write;
            paddr_q     <= i_cmd_addr;
            pwdata_q    <= i_cmd_write ? i_cmd_wdata : '0;
            pstrb_q     <= i_cmd_write ? i_cmd_wstrb : '0;
            wait_cnt_q  <= '0;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (i_pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_q.err     <= i_pslverr;
            rsp_q.timeout <= 1'b0;
            rsp_q.rdata   <= (!pwrite_q && !i_pslverr) ? i_prdata : '0;
            state_q       <= ST_RESP;
          end else if (timeout_hit) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            rsp_q.rdata   <= '0;
            wait_cnt_q    <= wait_cnt_d;
            state_q       <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_psel        = psel_q;
  assign o_penable     = penable_q;
  assign o_pwrite      = pwrite_q;
  assign o_paddr       = paddr_q;
  assign o_pwdata      = pwdata_q;
  assign o_pstrb       = pstrb_q;
  assign o_pprot       = Pprot;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_q.rdata;
  assign o_rsp_err     = rsp_q.err;
  assign o_rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_allegro_codec_cfg_apb_manager.sv
// Directed self-checking bench for the codec config APB manager.
// Instance uses a 4-cycle timeout so the abort boundary is reachable.
module tb_allegro_codec_cfg_apb_manager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_write = 1'b0;
  logic [19:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic [3:0]  i_cmd_wstrb = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_rsp_timeout;
  logic [19:0] o_paddr;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [2:0]  o_pprot;
  logic        i_pready = 1'b0;
  logic        i_pslverr = 1'b0;
  logic [31:0] i_prdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  allegro_codec_cfg_apb_manager #(
    .TimeoutCycles(4),
    .Pprot(3'b010)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err),
    .o_rsp_timeout(o_rsp_timeout),
    .o_paddr(o_paddr),
    .o_pwdata(o_pwdata),
    .o_pstrb(o_pstrb),
    .o_psel(o_psel),
    .o_penable(o_penable),
    .o_pwrite(o_pwrite),
    .o_pprot(o_pprot),
    .i_pready(i_pready),
    .i_pslverr(i_pslverr),
    .i_prdata(i_prdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return in the cycle after acceptance (SETUP).
  task automatic issue(input logic wr, input logic [19:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int k;
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_wdata = d;
    i_cmd_wstrb = s;
    k = 0;
    while (o_cmd_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (o_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready: got %0b exp 1", o_cmd_ready);
    end
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    n_cmp++;
    if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rsp_done: got %b exp 01", {o_rsp_valid, o_cmd_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (o_cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_cmd_ready: got %0b exp 0", o_cmd_ready);
    end
    n_cmp++;
    if ({o_psel, o_penable, o_pwrite} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_ctrl: got %b exp 000", {o_psel, o_penable, o_pwrite});
    end
    n_cmp++;
    if ({o_paddr, o_pwdata, o_pstrb} !== 56'h0) begin
      n_err++;
      $display("FAIL rst_apb: got %h exp 0", {o_paddr, o_pwdata, o_pstrb});
    end
    n_cmp++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_timeout, o_rsp_rdata} !== 35'h0) begin
      n_err++;
      $display("FAIL rst_rsp: got %h exp 0",
               {o_rsp_valid, o_rsp_err, o_rsp_timeout, o_rsp_rdata});
    end
    n_cmp++;
    if (o_pprot !== 3'b010) begin
      n_err++;
      $display("FAIL pprot: got %b exp 010", o_pprot);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (o_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_release_ready: got %0b exp 1", o_cmd_ready);
    end
  endtask

  task automatic test_write();
    i_pready = 1'b1;
    issue(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF);
    n_cmp++;
    if ({o_psel, o_penable, o_pwrite, o_cmd_ready} !== 4'b1010) begin
      n_err++;
      $display("FAIL wr_setup: got %b exp 1010",
               {o_psel, o_penable, o_pwrite, o_cmd_ready});
    end
    n_cmp++;
    if ({o_paddr, o_pwdata, o_pstrb} !== {20'h00010, 32'hDEADBEEF, 4'hF}) begin
      n_err++;
      $display("FAIL wr_apb: got %h exp 00010deadbeeff",
               {o_paddr, o_pwdata, o_pstrb});
    end
    tick();
    n_cmp++;
    if ({o_psel, o_penable, o_rsp_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL wr_access: got %b exp 110", {o_psel, o_penable, o_rsp_valid});
    end
    tick();
    n_cmp++;
    if ({o_psel, o_penable, o_rsp_valid, o_rsp_err, o_rsp_timeout}
        !== 5'b00100) begin
      n_err++;
      $display("FAIL wr_rsp: got %b exp 00100",
               {o_psel, o_penable, o_rsp_valid, o_rsp_err, o_rsp_timeout});
    end
    n_cmp++;
    if (o_rsp_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL wr_rdata: got %h exp 0", o_rsp_rdata);
    end
    i_pready = 1'b0;
    finish_rsp();
  endtask

  task automatic test_read_wait();
    i_pready = 1'b0;
    issue(1'b0, 20'h00404, 32'h0, 4'hF);
    n_cmp++;
    if ({o_psel, o_penable, o_pwrite, o_paddr, o_pstrb}
        !== {3'b100, 20'h00404, 4'h0}) begin
      n_err++;
      $display("FAIL rd_setup: got %h", {o_psel, o_penable, o_pwrite, o_paddr, o_pstrb});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({o_psel, o_penable, o_paddr, o_pstrb, o_rsp_valid}
          !== {2'b11, 20'h00404, 4'h0, 1'b0}) begin
        n_err++;
        $display("FAIL rd_access%0d: got %h", i,
                 {o_psel, o_penable, o_paddr, o_pstrb, o_rsp_valid});
      end
      if (i == 3) begin
        i_pready = 1'b1;
        i_prdata = 32'h12345678;
      end
    end
    tick();
    i_pready = 1'b0;
    n_cmp++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_timeout, o_psel} !== 4'b1000) begin
      n_err++;
      $display("FAIL rd_rsp_flags: got %b exp 1000",
               {o_rsp_valid, o_rsp_err, o_rsp_timeout, o_psel});
    end
    n_cmp++;
    if (o_rsp_rdata !== 32'h12345678) begin
      n_err++;
      $display("FAIL rd_rdata: got %h exp 12345678", o_rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_read_slverr();
    i_pready  = 1'b1;
    i_pslverr = 1'b1;
    i_prdata  = 32'hFFFFFFFF;
    issue(1'b0, 20'h00020, 32'h0, 4'h0);
    tick();
    tick();
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    n_cmp++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_timeout} !== 3'b110) begin
      n_err++;
      $display("FAIL slverr_flags: got %b exp 110",
               {o_rsp_valid, o_rsp_err, o_rsp_timeout});
    end
    n_cmp++;
    if (o_rsp_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL slverr_rdata: got %h exp 0", o_rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_timeout(input logic late_ready);
    i_pready = 1'b0;
    i_prdata = 32'hAAAA5555;
    issue(1'b0, 20'h00800, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({o_psel, o_penable, o_rsp_valid} !== 3'b110) begin
        n_err++;
        $display("FAIL to_access%0d(%0b): got %b exp 110", i, late_ready,
                 {o_psel, o_penable, o_rsp_valid});
      end
      if (i == 3) i_pready = late_ready;
    end
    tick();
    i_pready = 1'b0;
    n_cmp++;
    if ({o_psel, o_penable, o_rsp_valid} !== 3'b001) begin
      n_err++;
      $display("FAIL to_end(%0b): got %b exp 001", late_ready,
               {o_psel, o_penable, o_rsp_valid});
    end
    n_cmp++;
    if ({o_rsp_err, o_rsp_timeout} !== (late_ready ? 2'b00 : 2'b11)) begin
      n_err++;
      $display("FAIL to_flags(%0b): got %b", late_ready, {o_rsp_err, o_rsp_timeout});
    end
    n_cmp++;
    if (o_rsp_rdata !== (late_ready ? 32'hAAAA5555 : 32'h0)) begin
      n_err++;
      $display("FAIL to_rdata(%0b): got %h", late_ready, o_rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    i_pready  = 1'b1;
    i_pslverr = 1'b1;
    issue(1'b1, 20'h00044, 32'h0BADF00D, 4'h3);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 20'h00088;
    tick();
    tick();
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({o_rsp_valid, o_rsp_err, o_rsp_timeout, o_rsp_rdata,
           o_cmd_ready, o_psel, o_penable} !== {3'b110, 32'h0, 3'b000}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got %h", i, {o_rsp_valid, o_rsp_err,
                 o_rsp_timeout, o_rsp_rdata, o_cmd_ready, o_psel, o_penable});
      end
      tick();
    end
    i_cmd_valid = 1'b0;
    finish_rsp();
    tick();
    n_cmp++;
    if (o_psel !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_xfer: got %0b exp 0", o_psel);
    end
  endtask

  task automatic test_reset_mid();
    i_pready = 1'b0;
    issue(1'b1, 20'h00123, 32'hCAFEF00D, 4'h5);
    tick();
    n_cmp++;
    if ({o_psel, o_penable} !== 2'b11) begin
      n_err++;
      $display("FAIL mid_access: got %b exp 11", {o_psel, o_penable});
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({o_psel, o_penable, o_pwrite, o_cmd_ready, o_rsp_valid,
         o_rsp_err, o_rsp_timeout} !== 7'b0) begin
      n_err++;
      $display("FAIL mid_rst_ctrl: got %b", {o_psel, o_penable, o_pwrite,
               o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout});
    end
    n_cmp++;
    if ({o_paddr, o_pwdata, o_pstrb, o_rsp_rdata} !== 88'h0) begin
      n_err++;
      $display("FAIL mid_rst_data: got %h", {o_paddr, o_pwdata, o_pstrb, o_rsp_rdata});
    end
    rst_n = 1'b1;
    i_pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({o_rsp_valid, o_psel} !== 2'b00) begin
        n_err++;
        $display("FAIL mid_after%0d: got %b exp 00", i, {o_rsp_valid, o_psel});
      end
    end
    i_pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_read_slverr();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1);
  end

endmodule

// File: doc/allegro_codec_cfg_apb_manager.md
ALLEGRO_CODEC_CFG_APB_MANAGER -- requirements
Module: allegro_codec_cfg_apb_manager

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 256, meaning ACCESS-phase cycles allowed before abort (0 = no timeout).
REQ-002 SHALL have parameter Pprot, default 3'b000, meaning constant value driven on o_pprot.
REQ-003 SHALL use one clock, i_clk; reset is i_rst_n, synchronous, active-low.
REQ-004 i_clk  input  1  block clock.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_cmd_valid / o_cmd_ready  input / output  1  command handshake.
REQ-007 i_cmd_write  input  1  1 = write, 0 = read.
REQ-008 i_cmd_addr  input  20  dcd_targ_cfg_apb_addr_t target address.
REQ-009 i_cmd_wdata  input  32  dcd_targ_cfg_apb_data_t write data.
REQ-010 i_cmd_wstrb  input  4  dcd_targ_cfg_apb_strb_t byte strobes.
REQ-011 o_rsp_valid / i_rsp_ready  output / input  1  response handshake.
REQ-012 o_rsp_rdata  output  32  read data (0 for writes and errors).
REQ-013 o_rsp_err  output  1  PSLVERR or timeout.
REQ-014 o_rsp_timeout  output  1  transfer aborted by timeout.
REQ-015 o_paddr, o_pwdata, o_pstrb  output  20/32/4  APB address, write data, strobes.
REQ-016 o_psel, o_penable, o_pwrite  output  1 each  APB controls; o_pprot output 3.
REQ-017 i_pready, i_pslverr  input  1 each; i_prdata input 32.

Function
REQ-018 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-019 o_cmd_ready SHALL be 1 only in IDLE; command accepted when i_cmd_valid && o_cmd_ready.
REQ-020 On accept, SHALL capture command into APB registers and go to SETUP next cycle: o_psel=1, o_penable=0.
REQ-021 SETUP SHALL last exactly one cycle, then ACCESS: o_psel=1, o_penable=1.
REQ-022 APB address/control/data SHALL be stable from SETUP until ACCESS completes.
REQ-023 o_pstrb SHALL equal i_cmd_wstrb for writes and 4'b0 for reads.
REQ-024 In ACCESS, i_pready=1 SHALL complete transfer: capture i_prdata (reads only), i_pslverr; o_psel=o_penable=0 next cycle; enter RESP.
REQ-025 Wait-state counter SHALL clear on SETUP entry, increment each ACCESS cycle with i_pready=0, saturate.
REQ-026 If TimeoutCycles>0 and counter reaches TimeoutCycles with i_pready still 0, SHALL abort: deassert o_psel/o_penable next cycle, enter RESP with o_rsp_err=1, o_rsp_timeout=1, o_rsp_rdata=0.
REQ-027 i_pready=1 in the same cycle the counter reaches the limit SHALL count as completion, not timeout.
REQ-028 Latency: accept at cycle N -> o_psel N+1, o_penable N+2, o_rsp_valid earliest N+3 (zero wait states).
REQ-029 RESP: o_rsp_valid=1, response fields stable until i_rsp_ready; on handshake go IDLE (o_cmd_ready=1 next cycle).
REQ-030 Write response SHALL have o_rsp_rdata=0; pslverr on read SHALL force o_rsp_rdata=0.
REQ-031 Single outstanding transfer; no command accepted outside IDLE.

Reset
REQ-032 On i_rst_n=0 at a clock edge: state IDLE, o_cmd_ready=0 during reset then 1, o_psel=o_penable=o_pwrite=0, o_paddr/o_pwdata/o_pstrb=0, o_rsp_valid=o_rsp_err=o_rsp_timeout=0, o_rsp_rdata=0.
REQ-033 Reset mid-transfer SHALL drop o_psel/o_penable next edge with no response issued.

Structure
REQ-034 APB addr/data/strb types SHALL come from allegro_codec_pkg; FSM state enum and response struct SHALL be added to that package.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Write addr 0x00010, data 0xDEADBEEF, strb 0xF, i_pready=1 immediately -> psel N+1, penable N+2, rsp_valid N+3, err=0, rdata=0.
REQ-037 Read addr 0x00404, i_pready after 3 wait states, prdata 0x12345678 -> rsp_rdata 0x12345678, o_pstrb=0 throughout, addr stable all 5 APB cycles.
REQ-038 Read with i_pslverr=1, prdata 0xFFFFFFFF -> rsp_err=1, rdata=0, timeout=0.
REQ-039 TimeoutCycles=4, i_pready held 0 -> psel drops after 4 ACCESS cycles, rsp err=1, timeout=1; i_pready=1 on 4th cycle -> normal completion.
REQ-040 i_rsp_ready held 0 for 10 cycles -> response stable, o_cmd_ready=0, no new APB transfer.
REQ-041 Assert i_rst_n=0 during ACCESS -> all outputs reset values next edge; no o_rsp_valid afterward.
